// File: rtl/mem_rsp_credit_buffer.sv
// rtl/mem_rsp_credit_buffer.sv - credit-throttled response FIFO for an unstallable memory port (optional MEM_RSP_BYPASS_EN)
module mem_rsp_credit_buffer #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 4,
  parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [DataWidth-1:0] mem_rdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_data_o,
  output logic [CntWidth-1:0]  outstanding_o,
  output logic                 overflow_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntWidth-1:0] DepthC  = CntWidth'(Depth);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [CntWidth-1:0]  level_q, level_d;
  logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
  logic                 overflow_q, overflow_d;
  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] mem_d [Depth];

  logic credit_ok, issue, pop, fifo_pop, push, do_write;
  logic fifo_empty, fifo_full, bypass;

  // Request throttling, response selection, credit counter and FIFO next state
  always_comb begin
    credit_ok   = (cnt_q < DepthC);
    mem_req_o   = req_valid_i & credit_ok;
    req_ready_o = credit_ok & mem_gnt_i;
    issue       = mem_req_o & mem_gnt_i;

    fifo_empty  = (level_q == '0);
    fifo_full   = (level_q == DepthC);

`ifdef MEM_RSP_BYPASS_EN
    // An empty FIFO with a consumer ready hands the response straight through.
    bypass      = fifo_empty & mem_rvalid_i & rsp_ready_i;
    rsp_valid_o = ~fifo_empty | bypass;
    rsp_data_o  = fifo_empty ? mem_rdata_i : mem_q[rd_ptr_q];
`else
    bypass      = 1'b0;
    rsp_valid_o = ~fifo_empty;
    rsp_data_o  = mem_q[rd_ptr_q];
`endif

    pop        = rsp_valid_o & rsp_ready_i;
    fifo_pop   = pop & ~bypass;
    push       = mem_rvalid_i & ~bypass;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_write   = push & (~fifo_full | fifo_pop);
    overflow_d = overflow_q | (push & fifo_full & ~fifo_pop);

    // Simultaneous issue and pop cancel; a pop with no credit in use leaves cnt at 0.
    cnt_d = cnt_q;
    if (issue && !pop) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (pop && !issue && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntWidth'(1);
    end

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_write) begin
      mem_d[wr_ptr_q] = mem_rdata_i;
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrWidth'(1);
    end
    if (fifo_pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrWidth'(1);
    end

    level_d = level_q;
    case ({do_write, fifo_pop})
      2'b10:   level_d = level_q + CntWidth'(1);
      2'b01:   level_d = level_q - CntWidth'(1);
      default: level_d = level_q;
    endcase

    outstanding_o = cnt_q;
    overflow_o    = overflow_q;
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      level_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: doc/mem_rsp_credit_buffer.md
# mem_rsp_credit_buffer

Response-side companion to the request spill stage in the AXI-to-memory path. It forwards valid/ready requests to a memory port that grants requests but cannot back-pressure its responses. It throttles issue with a credit counter so every in-flight response has a guaranteed slot. Responses returning on the unstallable `mem_rvalid_i` strobe are buffered in a FIFO and re-emitted as a valid/ready stream toward the AXI response channel.

## Interface
- `DataWidth`, default 32: response data width in bits.
- `Depth`, default 4: FIFO entries and maximum requests in flight; legal range is 1 or more.
- `CntWidth`, default `$clog2(Depth+1)`: width of the credit counter and `outstanding_o`; derived, not overridden.

Ports, in the order name, direction, width, meaning:
- `clk_i`  in  1  the single clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset; synchronous and active-low.
- `req_valid_i`  in  1  upstream request valid.
- `req_ready_o`  out  1  upstream request accepted.
- `mem_req_o`  out  1  request to memory.
- `mem_gnt_i`  in  1  memory grant.
- `mem_rvalid_i`  in  1  memory response strobe; no back-pressure.
- `mem_rdata_i`  in  DataWidth  memory response data.
- `rsp_valid_o`  out  1  downstream response valid.
- `rsp_ready_i`  in  1  downstream response ready.
- `rsp_data_o`  out  DataWidth  downstream response data.
- `outstanding_o`  out  CntWidth  requests issued and not yet popped downstream.
- `overflow_o`  out  1  sticky flag for a protocol violation (response arrived with the FIFO full).

## Operation
- **Credit check:** `credit_ok = (cnt < Depth)`.
- **Request path (combinational):**
  - `mem_req_o = req_valid_i & credit_ok`
  - `req_ready_o = credit_ok & mem_gnt_i`
  - `issue = mem_req_o & mem_gnt_i`
- **Pop:** `pop = rsp_valid_o & rsp_ready_i`.
- **Counter update:**
  - `issue` alone: `cnt + 1`.
  - `pop` alone: `cnt - 1`.
  - Both in the same cycle: unchanged.
  - The counter never exceeds `Depth` and never goes below 0.
- **FIFO storage:**
  - Circular buffer of `Depth` entries with read pointer, write pointer and fill level.
  - Pointers wrap from `Depth-1` to 0.
  - Non-power-of-two `Depth` must wrap correctly.
- **Push:** `mem_rvalid_i` pushes `mem_rdata_i`, except when the push is bypassed (see Configuration).
- **Output:** `rsp_valid_o` is high while the FIFO is non-empty; `rsp_data_o` is the head entry.
- **Push and pop in one cycle:**
  - Fill level is unchanged.
  - With the FIFO full, the push is legal because the pop frees the slot in the same cycle.
- **Overflow:**
  - Condition: push while full and no pop.
  - The data is dropped and FIFO state is unchanged.
  - `overflow_o` sets and stays set until reset.
  - The credit scheme makes this unreachable for compliant memories.
- **Response without request:** `mem_rvalid_i` with `cnt == 0` is still pushed; `cnt` is not altered.
- **Reset:**
  - Reset is synchronous. Asserting it mid-operation clears `cnt`, the pointers, the fill level and `overflow_o` at the next edge.
  - In-flight responses are discarded.

## Timing
- **Reset values:**
  - `rsp_valid_o = 0`, `outstanding_o = 0`, `overflow_o = 0`.
  - `rsp_data_o` is don't-care while `rsp_valid_o = 0`.
  - `mem_req_o` and `req_ready_o` follow their inputs combinationally, with `credit_ok = 1`.
- **Issue latency:** zero cycles from `req_valid_i` to `mem_req_o`.
- **Response latency (no bypass):** response stored at edge N; `rsp_valid_o` high in cycle N+1.
- **Stability:** once high, `rsp_valid_o` and `rsp_data_o` stay stable until `pop`.
- **Throughput:** sustains one request and one response per cycle when `rsp_ready_i` is held high.
- **`outstanding_o`:** reflects the registered `cnt`, so it updates one cycle after `issue`/`pop`.
- **Credit release:** a credit freed by `pop` at edge N permits an issue in cycle N+1, not in the same cycle.

## Configuration
- **`MEM_RSP_BYPASS_EN` defined:**
  - Applies when the FIFO is empty, `mem_rvalid_i` is high and `rsp_ready_i` is high.
  - `rsp_valid_o = 1` and `rsp_data_o = mem_rdata_i` in the same cycle.
  - The response is counted as a pop and is not stored.
  - Zero-cycle response latency.
- **Not defined:**
  - All responses pass through the FIFO.
  - `rsp_valid_o` and `rsp_data_o` are driven purely from registers.
  - One-cycle minimum latency.

## Test plan
- **Basic round trip:**
  - Stimulus: after reset, `Depth=4`, drive one request with `mem_gnt_i=1`; return `mem_rdata_i=32'hA5A5_0001` two cycles later; `rsp_ready_i=1`.
  - Response: `outstanding_o` goes 0→1→0; without bypass, `rsp_valid_o` is high the cycle after `mem_rvalid_i`, carrying the same data.
- **Credit exhaustion:**
  - Stimulus: hold `rsp_ready_i=0` and issue 4 granted requests, then a 5th.
  - Response: `mem_req_o=0` and `req_ready_o=0` for the 5th; `outstanding_o=4`.
  - Then pop one and confirm the 5th issues the following cycle.
- **Simultaneous issue and pop at `cnt=4`:**
  - Stimulus: with 4 responses buffered, pop every cycle with a new request pending.
  - Response: issue resumes one cycle after each pop; `cnt` stays in 3..4; no `overflow_o`.
- **FIFO wrap:**
  - Stimulus: `Depth=3`, 10 back-to-back responses with data 0..9 and random `rsp_ready_i`.
  - Response: the downstream order is exactly 0..9 with no loss or duplication.
- **Overflow and mid-operation reset:**
  - Stimulus: force 5 `mem_rvalid_i` pulses with `rsp_ready_i=0` and `Depth=4`.
  - Response: `overflow_o=1` and the 5th datum is dropped.
  - Then assert `rst_ni=0` for one edge: all status clears and `rsp_valid_o=0`.
- **Bypass (`MEM_RSP_BYPASS_EN`):**
  - Stimulus: FIFO empty, `mem_rvalid_i=1` with `32'hDEAD_BEEF`, `rsp_ready_i=1`.
  - Response: `rsp_valid_o=1` with `32'hDEAD_BEEF` in the same cycle; FIFO stays empty.
  - Without the macro, the same response appears one cycle later.
